// File: rtl/simon_sequence_player.sv
// Simon Says sequence generator and player: appends LFSR-drawn symbols (0-5) to a small
// memory and replays the stored sequence as timed on/blank intervals for the 7-segment decoder.
module simon_sequence_player #(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      extend,
    input  logic                      play,
    output logic [7:0]                hex_input,
    output logic                      sym_valid,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(MAX_LEN):0]  len,
    output logic                      full,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [2:0]                rd_data
);
    localparam int unsigned AW   = $clog2(MAX_LEN);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {StIdle, StGen, StShowOn, StShowOff, StDone} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [2:0]      rd_data_q;
    logic            mem_we;
    logic [2:0]      mem [MAX_LEN];

    // Galois LFSR, x^16+x^14+x^13+x^11; never reaches zero from a nonzero seed.
    assign lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            lfsr_q    <= lfsr_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem[len_q[AW-1:0]] <= lfsr_q[2:0];
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = '0;
                    state_d = StGen;
                end else if (extend) begin
                    if (len_q != LW'(MAX_LEN)) begin
                        state_d = StGen;
                    end else begin
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = StShowOn;
                    end
                end else if (play) begin
                    if (len_q != '0) begin
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = StShowOn;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StGen: begin
                // Rejection sampling: draws of 6 or 7 are discarded and the next cycle retries.
                if (lfsr_q[2:0] < 3'd6) begin
                    mem_we  = 1'b1;
                    len_d   = len_q + 1'b1;
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = StShowOn;
                end
            end
            StShowOn: begin
                if (timer_q == TW'(ON_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = StShowOff;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StShowOff: begin
                if (timer_q == TW'(OFF_CYCLES - 1)) begin
                    timer_d = '0;
                    if ({1'b0, idx_q} == len_q - LW'(1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StShowOn;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hex_input = 8'hFF;
        sym_valid = 1'b0;
        if (state_q == StShowOn) begin
            hex_input = {5'b0, mem[idx_q]};
            sym_valid = 1'b1;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign len     = len_q;
    assign full    = (len_q == LW'(MAX_LEN));
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Bench for simon_sequence_player: per-cycle expected display timeline queued at each command
// from an LFSR reference model, popped and compared each cycle.
module tb_simon_sequence_player;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned ON      = 4;
    localparam int unsigned OFF     = 2;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_n, start, extend, play;
    logic [7:0] hex_input;
    logic       sym_valid, busy, done, full;
    logic [4:0] len;
    logic [3:0] rd_addr;
    logic [2:0] rd_data;

    simon_sequence_player #(
        .MAX_LEN(MAX_LEN), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .extend(extend), .play(play),
        .hex_input(hex_input), .sym_valid(sym_valid), .busy(busy), .done(done),
        .len(len), .full(full), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] hex;
        logic       valid;
        logic       busy;
        logic       done;
    } cyc_t;

    typedef struct {
        logic       s;
        logic       e;
        logic       p;
        logic [4:0] exp_len;
        logic       exp_full;
    } vec_t;

    cyc_t       exp_q[$];
    logic [2:0] model_seq[$];
    logic [15:0] m_lfsr;
    int checks = 0;
    int passes = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_cyc(input logic [7:0] h, input logic v, input logic b, input logic d);
        cyc_t c;
        c.hex = h; c.valid = v; c.busy = b; c.done = d;
        exp_q.push_back(c);
    endtask

    // Drive one command, queue the expected cycle-by-cycle response, then pop and compare.
    // extend_at >= 0 pulses extend mid-playback; abort_at >= 0 stops comparing at that cycle.
    task automatic issue(input logic s, input logic e, input logic p,
                         input int extend_at, input int abort_at);
        logic [15:0] l;
        bit append, show;
        int n;
        cyc_t c;
        @(negedge clk);
        start = s; extend = e; play = p;
        @(posedge clk);
        #1;
        start = 0; extend = 0; play = 0;
        append = 0;
        show = 0;
        if (s) begin
            model_seq.delete();
            append = 1;
        end else if (e) begin
            append = (model_seq.size() < MAX_LEN);
            show = 1;
        end else if (p) begin
            show = 1;
        end
        if (append) begin
            l = m_lfsr;
            forever begin
                push_cyc(8'hFF, 1'b0, 1'b1, 1'b0);
                if (l[2:0] < 3'd6) break;
                l = lfsr_step(l);
            end
            model_seq.push_back(l[2:0]);
        end
        if (append || show) begin
            foreach (model_seq[i]) begin
                repeat (ON)  push_cyc({5'b0, model_seq[i]}, 1'b1, 1'b1, 1'b0);
                repeat (OFF) push_cyc(8'hFF, 1'b0, 1'b1, 1'b0);
            end
            push_cyc(8'hFF, 1'b0, 1'b1, 1'b1);
        end
        push_cyc(8'hFF, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            extend = (n == extend_at);
            if (n == abort_at) begin
                exp_q.delete();
                break;
            end
            c = exp_q.pop_front();
            check($sformatf("hex_input[c%0d]", n), 16'(hex_input), 16'(c.hex));
            check($sformatf("sym_valid[c%0d]", n), 16'(sym_valid), 16'(c.valid));
            check($sformatf("busy[c%0d]", n), 16'(busy), 16'(c.busy));
            check($sformatf("done[c%0d]", n), 16'(done), 16'(c.done));
            n++;
        end
        extend = 0;
    endtask

    task automatic check_mem();
        foreach (model_seq[i]) begin
            @(negedge clk);
            rd_addr = 4'(i);
            @(posedge clk);
            #1;
            check($sformatf("rd_data[%0d]", i), 16'(rd_data), 16'(model_seq[i]));
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 0, 0, 5'd1, 0};
        vecs[1] = '{0, 1, 0, 5'd2, 0};
        vecs[2] = '{0, 1, 0, 5'd3, 0};
        vecs[3] = '{0, 1, 0, 5'd4, 0};
        vecs[4] = '{0, 0, 1, 5'd4, 0};
        vecs[5] = '{1, 1, 0, 5'd1, 0};   // start beats extend
        vecs[6] = '{0, 1, 1, 5'd2, 0};   // extend beats play

        reset_n = 0; start = 0; extend = 0; play = 0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset hex_input", 16'(hex_input), 16'h00FF);
        check("reset sym_valid", 16'(sym_valid), 16'd0);
        check("reset busy", 16'(busy), 16'd0);
        check("reset done", 16'(done), 16'd0);
        check("reset len", 16'(len), 16'd0);
        check("reset full", 16'(full), 16'd0);
        check("reset rd_data", 16'(rd_data), 16'd0);
        reset_n = 1;

        for (int v = 0; v < 7; v++) begin
            issue(vecs[v].s, vecs[v].e, vecs[v].p, -1, -1);
            check($sformatf("vec%0d len", v), 16'(len), 16'(vecs[v].exp_len));
            check($sformatf("vec%0d full", v), 16'(full), 16'(vecs[v].exp_full));
            if (v == 0 || v == 3) check_mem();
        end

        // extend pulsed during playback is ignored
        issue(0, 1, 0, 8, -1);
        check("ignored extend len", 16'(len), 16'd3);

        // reset during SHOW_ON of the second symbol
        issue(0, 0, 1, -1, 7);
        reset_n = 0;
        @(posedge clk);
        #1;
        model_seq.delete();
        check("midreset hex_input", 16'(hex_input), 16'h00FF);
        check("midreset sym_valid", 16'(sym_valid), 16'd0);
        check("midreset len", 16'(len), 16'd0);
        check("midreset busy", 16'(busy), 16'd0);
        @(negedge clk);
        reset_n = 1;

        // play on an empty sequence: straight to DONE
        issue(0, 0, 1, -1, -1);
        check("empty play len", 16'(len), 16'd0);

        // first draw after reset confirms the LFSR restarted from the seed
        issue(1, 0, 0, -1, -1);
        check_mem();
        for (int k = 2; k <= MAX_LEN; k++) begin
            issue(0, 1, 0, -1, -1);
            check($sformatf("grow len%0d", k), 16'(len), 16'(k));
        end
        check("full flag", 16'(full), 16'd1);
        issue(0, 1, 0, -1, -1);
        check("full extend len", 16'(len), 16'd16);
        check("full extend full", 16'(full), 16'd1);
        check_mem();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
